// File: rtl/alu_ex_pkg.sv
// Shared definitions for the integer execute stage and its neighbours (decoder, rs).
// Holds the default widths, the reserved "no dependency" tag, the op code map and
// the CDB payload layout {qd, vd, jump, target}.
package alu_ex_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 5;
  localparam int OP_W_DEF   = 6;

  // Tag 0 means "operand already resolved"; a real producer never carries it.
  localparam logic [TAG_W_DEF-1:0] TAG_NONE = '0;

  typedef enum logic [OP_W_DEF-1:0] {
    OP_NOP   = 6'd0,
    OP_ADD   = 6'd1,
    OP_SUB   = 6'd2,
    OP_AND   = 6'd3,
    OP_OR    = 6'd4,
    OP_XOR   = 6'd5,
    OP_SLL   = 6'd6,
    OP_SRL   = 6'd7,
    OP_SRA   = 6'd8,
    OP_SLT   = 6'd9,
    OP_SLTU  = 6'd10,
    OP_ADDI  = 6'd11,
    OP_ANDI  = 6'd12,
    OP_ORI   = 6'd13,
    OP_XORI  = 6'd14,
    OP_SLLI  = 6'd15,
    OP_SRLI  = 6'd16,
    OP_SRAI  = 6'd17,
    OP_SLTI  = 6'd18,
    OP_SLTIU = 6'd19,
    OP_LUI   = 6'd20,
    OP_AUIPC = 6'd21,
    OP_JAL   = 6'd22,
    OP_JALR  = 6'd23,
    OP_BEQ   = 6'd24,
    OP_BNE   = 6'd25,
    OP_BLT   = 6'd26,
    OP_BGE   = 6'd27,
    OP_BLTU  = 6'd28,
    OP_BGEU  = 6'd29
  } op_e;

  // CDB payload as broadcast to rs, LSB and ROB.
  typedef struct packed {
    logic [TAG_W_DEF-1:0]  qd;
    logic [DATA_W_DEF-1:0] vd;
    logic                  jump;
    logic [DATA_W_DEF-1:0] target;
  } cdb_pkt_t;

endpackage

// File: rtl/alu_ex_core.sv
// alu_core: combinational ALU plus branch/jump resolution for one issued op.
// Ports: op/pc/imm/vs1/vs2 in; vd (result), jump (control transfer taken), target (next PC) out.
// Latency 0; no state, no backpressure. Undefined op codes give vd=0, jump=0, target=pc+4.
module alu_core
  import alu_ex_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] vs1,
  input  logic [DATA_W-1:0] vs2,
  output logic [DATA_W-1:0] vd,
  output logic              jump,
  output logic [DATA_W-1:0] target
);

  logic              use_imm;
  logic              is_branch;
  logic [DATA_W-1:0] opb;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] pc4;
  logic [DATA_W-1:0] pc_imm;

  always_comb begin
    use_imm   = 1'b0;
    is_branch = 1'b0;
    case (op)
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
      OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU: use_imm = 1'b1;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: is_branch = 1'b1;
      default: ;
    endcase
  end

  assign opb    = use_imm ? imm : vs2;
  assign shamt  = opb[4:0];
  assign pc4    = pc + DATA_W'(4);
  assign pc_imm = pc + imm;

  always_comb begin
    vd     = '0;
    jump   = 1'b0;
    target = pc4;
    case (op)
      OP_ADD,  OP_ADDI:  vd = vs1 + opb;
      OP_SUB:            vd = vs1 - opb;
      OP_AND,  OP_ANDI:  vd = vs1 & opb;
      OP_OR,   OP_ORI:   vd = vs1 | opb;
      OP_XOR,  OP_XORI:  vd = vs1 ^ opb;
      OP_SLL,  OP_SLLI:  vd = vs1 << shamt;
      OP_SRL,  OP_SRLI:  vd = vs1 >> shamt;
      OP_SRA,  OP_SRAI:  vd = $unsigned($signed(vs1) >>> shamt);
      OP_SLT,  OP_SLTI:  vd = {{(DATA_W-1){1'b0}}, ($signed(vs1) < $signed(opb))};
      OP_SLTU, OP_SLTIU: vd = {{(DATA_W-1){1'b0}}, (vs1 < opb)};
      OP_LUI:            vd = imm;
      OP_AUIPC:          vd = pc_imm;
      OP_JAL: begin
        vd     = pc4;
        jump   = 1'b1;
        target = pc_imm;
      end
      OP_JALR: begin
        vd     = pc4;
        jump   = 1'b1;
        target = (vs1 + imm) & ~DATA_W'(1);
      end
      OP_BEQ:  jump = (vs1 == vs2);
      OP_BNE:  jump = (vs1 != vs2);
      OP_BLT:  jump = ($signed(vs1) <  $signed(vs2));
      OP_BGE:  jump = ($signed(vs1) >= $signed(vs2));
      OP_BLTU: jump = (vs1 <  vs2);
      OP_BGEU: jump = (vs1 >= vs2);
      default: ;
    endcase
    // Branches keep vd=0; only a taken branch redirects to pc+imm.
    if (is_branch && jump) target = pc_imm;
  end

endmodule

// File: rtl/alu_ex.sv
// alu_ex: integer execute stage; computes issued ops and queues results for the CDB.
// Latency: issue in cycle N -> oCDB_En in N+1 (0 with ALU_CDB_BYPASS_EN defined and FIFO empty).
// Backpressure: oRS_Full when the result FIFO holds FIFO_DEPTH entries; head holds until iCDB_Gnt.
// Ports: clk/rst (sync, active-high), en (global stall), iFlush; iRS_* issue side;
//        oCDB_* head-of-FIFO broadcast, iCDB_Gnt consumes the head.
// Optional macro ALU_CDB_BYPASS_EN: an op issued into an empty FIFO drives the CDB the same cycle.
module alu_ex
  import alu_ex_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int OP_W       = OP_W_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              iFlush,
  input  logic              iRS_En,
  input  logic [OP_W-1:0]   iRS_Op,
  input  logic [DATA_W-1:0] iRS_Pc,
  input  logic [DATA_W-1:0] iRS_Imm,
  input  logic [DATA_W-1:0] iRS_Vs1,
  input  logic [DATA_W-1:0] iRS_Vs2,
  input  logic [TAG_W-1:0]  iRS_Qd,
  output logic              oRS_Full,
  output logic              oCDB_En,
  output logic [TAG_W-1:0]  oCDB_Qd,
  output logic [DATA_W-1:0] oCDB_Vd,
  output logic              oCDB_Jump,
  output logic [DATA_W-1:0] oCDB_Target,
  input  logic              iCDB_Gnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

  // Same field order as cdb_pkt_t, sized by this instance's parameters.
  typedef struct packed {
    logic [TAG_W-1:0]  qd;
    logic [DATA_W-1:0] vd;
    logic              jump;
    logic [DATA_W-1:0] target;
  } pkt_t;

  pkt_t             mem [FIFO_DEPTH];
  pkt_t             res;
  pkt_t             head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             push_ok;
  logic             bypass;
  logic             wr;
  logic             rd;

  alu_core #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_core (
    .op     (iRS_Op),
    .pc     (iRS_Pc),
    .imm    (iRS_Imm),
    .vs1    (iRS_Vs1),
    .vs2    (iRS_Vs2),
    .vd     (res.vd),
    .jump   (res.jump),
    .target (res.target)
  );
  assign res.qd = iRS_Qd;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // Issue while full is dropped; flush and stall both suppress the push.
  assign push_ok = en & iRS_En & ~iFlush & ~full;

`ifdef ALU_CDB_BYPASS_EN
  assign bypass = push_ok & empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed result that is granted immediately never needs a FIFO slot.
  assign wr = push_ok & ~(bypass & iCDB_Gnt);
  assign rd = en & ~iFlush & iCDB_Gnt & ~empty;

  assign head        = bypass ? res : mem[rd_ptr];
  assign oRS_Full    = full;
  assign oCDB_En     = en & (~empty | bypass);
  assign oCDB_Qd     = head.qd;
  assign oCDB_Vd     = head.vd;
  assign oCDB_Jump   = head.jump;
  assign oCDB_Target = head.target;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (iFlush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr) wr_ptr <= wr_ptr + 1'b1;
        if (rd) rd_ptr <= rd_ptr + 1'b1;
        case ({wr, rd})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (!rst && wr) mem[wr_ptr] <= res;
  end

endmodule
